// File: rtl/vdp_bridge_pkg.sv
// Shared encodings and bus-cycle decode for the VDP host bridge.
// Used by vdp_host_bridge and vdp_bus_timer.
package vdp_bridge_pkg;

    localparam int STROBE_CYC_DEF = 4;
    localparam int GAP_CYC_DEF    = 8;

    localparam logic [7:0] CTRL_REG_PFX   = 8'h80;
    localparam logic [7:0] CTRL_WADDR_PFX = 8'h40;

    localparam logic MODE_DATA = 1'b0;
    localparam logic MODE_CTRL = 1'b1;

    typedef enum logic [1:0] {
        OP_WREG  = 2'd0,
        OP_WVRAM = 2'd1,
        OP_RVRAM = 2'd2,
        OP_RSTAT = 2'd3
    } vdp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_GAP
    } bridge_state_e;

    typedef struct packed {
        logic       mode;
        logic       rd;
        logic [7:0] dout;
    } bus_cyc_t;

    // Steps 0/1 are the control (address/register) writes, step 2 the data cycle.
    function automatic logic [1:0] last_step(input vdp_op_e op);
        case (op)
            OP_WREG:  return 2'd1;
            OP_RSTAT: return 2'd0;
            default:  return 2'd2;
        endcase
    endfunction

    function automatic bus_cyc_t bus_cycle(input vdp_op_e    op,
                                           input logic [1:0] step,
                                           input logic [13:0] addr,
                                           input logic [7:0] data);
        bus_cyc_t c;
        c.mode = MODE_CTRL;
        c.rd   = 1'b0;
        c.dout = 8'h00;
        case (op)
            OP_WREG: begin
                c.dout = (step == 2'd0) ? data : (CTRL_REG_PFX | {5'b00000, addr[2:0]});
            end
            OP_RSTAT: begin
                c.rd = 1'b1;
            end
            default: begin
                if (step == 2'd0) begin
                    c.dout = addr[7:0];
                end else if (step == 2'd1) begin
                    c.dout = {2'b00, addr[13:8]} | ((op == OP_WVRAM) ? CTRL_WADDR_PFX : 8'h00);
                end else begin
                    c.mode = MODE_DATA;
                    c.rd   = (op == OP_RVRAM);
                    c.dout = (op == OP_WVRAM) ? data : 8'h00;
                end
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vdp_bus_timer.sv
// One bus cycle = 1 setup clock, STROBE_CYC strobe clocks, GAP_CYC idle clocks.
// strobe is registered so the VDP strobes come straight from flops.
module vdp_bus_timer
    import vdp_bridge_pkg::*;
#(
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF
) (
    input  logic clk40m,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic strobe,
    output logic last_strobe,
    output logic done
);

    localparam logic [8:0] STB_END = 9'(STROBE_CYC);
    localparam logic [8:0] CYC_END = 9'(STROBE_CYC + GAP_CYC);

    logic [8:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       strobe_q, strobe_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            cnt_d  = 9'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == CYC_END) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 9'd1;
            end
        end
        strobe_d = busy_d && (cnt_d != 9'd0) && (cnt_d <= STB_END);
    end

    always_ff @(posedge clk40m) begin
        if (!rst_n) begin
            cnt_q    <= 9'd0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
        end
    end

    assign busy        = busy_q;
    assign strobe      = strobe_q;
    assign last_strobe = busy_q && (cnt_q == STB_END);
    assign done        = busy_q && (cnt_q == CYC_END);

endmodule

// File: rtl/vdp_host_bridge.sv
// Host command to VDP bus-cycle bridge (WREG/WVRAM/RVRAM/RSTAT).
// Define VDP_HOST_BRIDGE_ADDR_CACHE_EN to skip address writes on sequential VRAM access.
module vdp_host_bridge
    import vdp_bridge_pkg::*;
#(
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int GAP_CYC    = GAP_CYC_DEF
) (
    input  logic        clk40m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [13:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        vdp_mode,
    output logic [7:0]  vdp_dout,
    input  logic [7:0]  vdp_din,
    output logic        vdp_in_n,
    output logic        vdp_out_n
);

    bridge_state_e state_q, state_d;
    logic          ready_q, ready_d;
    vdp_op_e       op_q, op_d;
    logic [13:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    step_q, step_d;
    bus_cyc_t      cyc_q, cyc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;

    vdp_op_e    cmd_op_e;
    logic       accept;
    logic       cache_hit;
    logic [1:0] start_step;
    logic [1:0] step_inc;
    logic       tmr_start, tmr_busy, tmr_strobe, tmr_last, tmr_done;

    assign cmd_op_e   = vdp_op_e'(cmd_op);
    assign accept     = cmd_valid && ready_q && !tmr_busy;
    assign start_step = cache_hit ? 2'd2 : 2'd0;
    assign step_inc   = step_q + 2'd1;

`ifdef VDP_HOST_BRIDGE_ADDR_CACHE_EN
    logic        cv_q, cv_d;
    logic        cdir_q, cdir_d;
    logic [13:0] cnext_q, cnext_d;
    logic        is_vram, is_rd;

    assign is_vram   = (cmd_op_e == OP_WVRAM) || (cmd_op_e == OP_RVRAM);
    assign is_rd     = (cmd_op_e == OP_RVRAM);
    assign cache_hit = cv_q && is_vram && (cdir_q == is_rd) && (cmd_addr == cnext_q);

    // Shadow of the VDP auto-incrementing pointer; updated at acceptance since
    // an accepted command always completes unless reset, which clears it.
    always_comb begin
        cv_d    = cv_q;
        cdir_d  = cdir_q;
        cnext_d = cnext_q;
        if (accept) begin
            if (is_vram) begin
                cv_d    = 1'b1;
                cdir_d  = is_rd;
                cnext_d = cmd_addr + 14'd1;
            end else begin
                cv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk40m) begin
        if (!rst_n) begin
            cv_q    <= 1'b0;
            cdir_q  <= 1'b0;
            cnext_q <= 14'd0;
        end else begin
            cv_q    <= cv_d;
            cdir_q  <= cdir_d;
            cnext_q <= cnext_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        step_d      = step_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        tmr_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = cmd_op_e;
                    addr_d    = cmd_addr;
                    data_d    = cmd_data;
                    step_d    = start_step;
                    cyc_d     = bus_cycle(cmd_op_e, start_step, cmd_addr, cmd_data);
                    tmr_start = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_last) begin
                    state_d = ST_GAP;
                    if (cyc_q.rd) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = vdp_din;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    if (step_q == last_step(op_q)) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        step_d    = step_inc;
                        cyc_d     = bus_cycle(op_q, step_inc, addr_q, data_q);
                        tmr_start = 1'b1;
                        state_d   = ST_STROBE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // ready_q stays 0 through reset and rises on the first clock after release.
    always_ff @(posedge clk40m) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            op_q        <= OP_WREG;
            addr_q      <= 14'd0;
            data_q      <= 8'h00;
            step_q      <= 2'd0;
            cyc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            ready_q     <= (state_d == ST_IDLE) ? 1'b1 : ready_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            step_q      <= step_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    vdp_bus_timer #(
        .STROBE_CYC (STROBE_CYC),
        .GAP_CYC    (GAP_CYC)
    ) u_timer (
        .clk40m      (clk40m),
        .rst_n       (rst_n),
        .start       (tmr_start),
        .busy        (tmr_busy),
        .strobe      (tmr_strobe),
        .last_strobe (tmr_last),
        .done        (tmr_done)
    );

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign vdp_mode  = cyc_q.mode;
    assign vdp_dout  = cyc_q.dout;
    assign vdp_in_n  = ~(tmr_strobe & cyc_q.rd);
    assign vdp_out_n = ~(tmr_strobe & ~cyc_q.rd);

endmodule

// File: tb/tb_vdp_host_bridge.sv
// Directed bench for vdp_host_bridge: bus-cycle scoreboard plus strobe timing monitor.
module tb_vdp_host_bridge;

    localparam int STB = 4;
    localparam int GAP = 8;
    localparam int CYC = 1 + STB + GAP;
`ifdef VDP_HOST_BRIDGE_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk40m = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [13:0] cmd_addr = 14'd0;
    logic [7:0]  cmd_data = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        vdp_mode;
    logic [7:0]  vdp_dout;
    logic [7:0]  vdp_din = 8'h00;
    logic        vdp_in_n;
    logic        vdp_out_n;

    always #12 clk40m = ~clk40m;

    vdp_host_bridge #(.STROBE_CYC(STB), .GAP_CYC(GAP)) dut (
        .clk40m    (clk40m),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .vdp_mode  (vdp_mode),
        .vdp_dout  (vdp_dout),
        .vdp_din   (vdp_din),
        .vdp_in_n  (vdp_in_n),
        .vdp_out_n (vdp_out_n)
    );

    typedef struct packed {
        logic       mode;
        logic       rd;
        logic [7:0] dout;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] rsp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         strobe_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ex_w(input logic mode, input logic [7:0] d);
        exp_q.push_back({mode, 1'b0, d});
    endtask

    task automatic ex_r(input logic mode, input logic [7:0] rdata);
        exp_q.push_back({mode, 1'b1, 8'h00});
        rsp_q.push_back(rdata);
    endtask

    // VDP-side monitor: pops the scoreboard at each strobe and checks timing/stability.
    initial begin : mon
        logic act, prev_act, cur_rd, stb_ok, seen, pmode, smode;
        logic [7:0] pdout, sdout;
        int stb_len, gap_len;
        ev_t e, o;
        prev_act = 1'b0; cur_rd = 1'b0; stb_ok = 1'b0; seen = 1'b0;
        pmode = 1'b0; smode = 1'b0; pdout = 8'h00; sdout = 8'h00;
        stb_len = 0; gap_len = 0;
        forever begin
            @(negedge clk40m);
            act = (vdp_in_n === 1'b0) || (vdp_out_n === 1'b0);
            if (rst_n !== 1'b1) begin
                seen = 1'b0;
                gap_len = 0;
                act = 1'b0;
            end else if (act && !prev_act) begin
                strobe_cnt++;
                if (seen) chk("gap_len_ok", gap_len >= GAP, 1);
                chk("setup_stable", {vdp_mode, vdp_dout}, {pmode, pdout});
                chk("cycle_expected", exp_q.size() > 0, 1);
                o = '{mode: vdp_mode, rd: (vdp_in_n === 1'b0), dout: vdp_dout};
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.rd) o.dout = 8'h00;
                    chk("bus_cycle", o, e);
                end
                cur_rd = (vdp_in_n === 1'b0);
                stb_ok = !(vdp_in_n === 1'b0 && vdp_out_n === 1'b0);
                smode = vdp_mode;
                sdout = vdp_dout;
                stb_len = 1;
            end else if (act) begin
                stb_len++;
                if ((vdp_in_n === 1'b0 && vdp_out_n === 1'b0) ||
                    vdp_mode !== smode || vdp_dout !== sdout) stb_ok = 1'b0;
            end else if (prev_act) begin
                chk("strobe_len", stb_len, STB);
                chk("strobe_hold", {stb_ok, vdp_mode, vdp_dout}, {1'b1, smode, sdout});
                chk("rsp_valid_pulse", rsp_valid, cur_rd);
                if (cur_rd) begin
                    chk("rsp_expected", rsp_q.size() > 0, 1);
                    if (rsp_q.size() > 0) chk("rsp_data", rsp_data, rsp_q.pop_front());
                end
                gap_len = 1;
                seen = 1'b1;
            end else begin
                gap_len++;
                if (rsp_valid !== 1'b0) chk("rsp_spurious", rsp_valid, 0);
            end
            pmode = vdp_mode;
            pdout = vdp_dout;
            prev_act = act;
        end
    end

    task automatic send(input logic [1:0] op, input logic [13:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk40m);
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk40m);
            n++;
        end
        chk("ready_before_send", cmd_ready, 1);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk40m);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_addr = 14'($urandom);
        cmd_data = 8'($urandom);
    endtask

    task automatic finish_cmd(input string tag, input int exp_lat);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk40m);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        repeat (2) @(negedge clk40m);
        chk({tag, "_drained"}, exp_q.size() + rsp_q.size(), 0);
    endtask

    task automatic vram(input logic rd, input logic [13:0] a, input logic [7:0] d,
                        input bit hit, input string tag);
        if (!(hit && CACHE)) begin
            ex_w(1'b1, a[7:0]);
            ex_w(1'b1, {1'b0, !rd, a[13:8]});
        end
        if (rd) ex_r(1'b0, vdp_din);
        else    ex_w(1'b0, d);
        send(rd ? 2'd2 : 2'd1, a, d);
        finish_cmd(tag, (hit && CACHE) ? CYC : 3 * CYC);
    endtask

    initial begin : main
        int n, base;
        repeat (3) @(negedge clk40m);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_in_n", vdp_in_n, 1);
        chk("rst_out_n", vdp_out_n, 1);
        chk("rst_mode_dout", {vdp_mode, vdp_dout}, 0);
        chk("rst_rsp", {rsp_valid, rsp_data}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk40m);
        chk("ready_after_release", cmd_ready, 1);

        ex_w(1'b1, 8'hE2); ex_w(1'b1, 8'h81);
        send(2'd0, 14'h0001, 8'hE2);
        finish_cmd("wreg", 2 * CYC);

        ex_w(1'b1, 8'h34); ex_w(1'b1, 8'h52); ex_w(1'b0, 8'h5A);
        send(2'd1, 14'h1234, 8'h5A);
        finish_cmd("wvram", 3 * CYC);

        vdp_din = 8'hA5;
        ex_w(1'b1, 8'hFF); ex_w(1'b1, 8'h3F); ex_r(1'b0, 8'hA5);
        send(2'd2, 14'h3FFF, 8'h00);
        finish_cmd("rvram_3fff", 3 * CYC);
        chk("rsp_data_held", rsp_data, 8'hA5);

        vdp_din = 8'h3C;
        vram(1'b1, 14'h0000, 8'h00, 1'b1, "rvram_wrap");

        vdp_din = 8'h80;
        ex_r(1'b1, 8'h80);
        send(2'd3, 14'h0000, 8'h00);
        finish_cmd("rstat", CYC);
        chk("rstat_data", rsp_data, 8'h80);

        vram(1'b0, 14'h0100, 8'h11, 1'b0, "w100");
        vram(1'b0, 14'h0101, 8'h22, 1'b1, "w101_seq");
        vram(1'b0, 14'h0100, 8'h33, 1'b0, "w100_again");
        ex_w(1'b1, 8'h12); ex_w(1'b1, 8'h87);
        send(2'd0, 14'h0007, 8'h12);
        finish_cmd("wreg7", 2 * CYC);
        vram(1'b0, 14'h0101, 8'h44, 1'b0, "w101_after_wreg");
        vdp_din = 8'h5C;
        vram(1'b1, 14'h0102, 8'h00, 1'b0, "r102_dir_change");
        vdp_din = 8'h96;
        vram(1'b1, 14'h0103, 8'h00, 1'b1, "r103_seq");

        // Reset during the second strobe of a WVRAM.
        ex_w(1'b1, 8'h00); ex_w(1'b1, 8'h42); ex_w(1'b0, 8'h55);
        base = strobe_cnt;
        send(2'd1, 14'h0200, 8'h55);
        n = 0;
        do begin
            @(negedge clk40m);
            #1;
            n++;
        end while (strobe_cnt < base + 2 && n < 200);
        chk("second_strobe_seen", strobe_cnt, base + 2);
        rst_n = 1'b0;
        @(negedge clk40m);
        chk("midrst_strobes", {vdp_in_n, vdp_out_n}, 2'b11);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk("midrst_outputs", {vdp_mode, vdp_dout, rsp_valid, rsp_data}, 0);
        exp_q.delete();
        rsp_q.delete();
        @(negedge clk40m);
        #1 rst_n = 1'b1;
        @(negedge clk40m);
        chk("midrst_ready_after_release", cmd_ready, 1);
        vram(1'b0, 14'h0201, 8'h66, 1'b0, "post_rst_wvram");
        vdp_din = 8'hC3;
        vram(1'b1, 14'h0202, 8'h00, 1'b0, "post_rst_rvram");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
